// File: rtl/truth_table_probe_pkg.sv
// ----------------------------------------------------------------------------
// truth_table_probe_pkg
//
// Shared types and constants for the truth-table characterizer.
//   state_e          FSM state encoding (IDLE/DRIVE/SAMPLE/FINISH)
//   NUM_VECTORS      number of input combinations of a 3-input gate
//   LAST_VECTOR      index of the final vector (7)
//   vec_bit_index()  maps vector k to its bit position in the code (7-k),
//                    so vector 000 lands in the MSB
// ----------------------------------------------------------------------------
package truth_table_probe_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int NUM_VECTORS = 8;
  localparam logic [2:0] LAST_VECTOR = 3'(NUM_VECTORS - 1);

  function automatic logic [2:0] vec_bit_index(input logic [2:0] k);
    return 3'd7 - k;
  endfunction

endpackage

// File: rtl/truth_table_probe_settle.sv
// ----------------------------------------------------------------------------
// settle_timer
//
// Counts the settle cycles of one input vector.
//   clk, rst   clock and synchronous active-high reset
//   load       restart the count; the cycle after load counts as cycle 1
//   expired    high in the cycle where the count has reached SETTLE_CYCLES
//   early      (TTP_GLITCH_CHECK_EN only) marks the edge on which the
//              early glitch-check sample of the gate output is taken
//
// The counter saturates at SETTLE_CYCLES, so it is $clog2(SETTLE_CYCLES+1)
// bits wide and never wraps.
//
// Build option: TTP_GLITCH_CHECK_EN adds the `early` output.
// ----------------------------------------------------------------------------
module settle_timer #(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
`ifdef TTP_GLITCH_CHECK_EN
  ,
  output logic early
`endif
);

  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(SETTLE_CYCLES);
  localparam logic [CW-1:0] ONE  = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = ONE;
    end else if (cnt_q != LAST) begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // The last settle cycle ends on the edge one before the sampling edge,
  // which is exactly where the early sample belongs.
  always_comb begin
    expired = (cnt_q == LAST);
  end

`ifdef TTP_GLITCH_CHECK_EN
  always_comb begin
    early = (cnt_q == LAST);
  end
`endif

endmodule

// File: rtl/truth_table_probe.sv
// ----------------------------------------------------------------------------
// truth_table_probe
//
// Characterizes a 3-input combinational gate: drives all eight input
// vectors onto in1/in2/in3 (in1 = MSB), samples the gate's `out` at the
// end of each vector window and assembles the 8-bit truth-table code,
// with code[7-k] = out for vector k.
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   start          one-cycle run request (ignored while busy)
//   busy           run in progress
//   done           one-cycle pulse: `code` (and `unstable`) just updated
//   code[7:0]      truth-table code of the last completed run
//   unstable       with done: gate output changed inside a sample window
//   in1, in2, in3  vector driven to the gate under test
//   out            gate output
//   dbg_state      current FSM state (state_e encoding), for checkers
//
// Each vector is held for SETTLE_CYCLES+1 cycles: SETTLE_CYCLES cycles in
// DRIVE and one in SAMPLE. `out` is captured on the edge that leaves
// SAMPLE, and the vector advances on that same edge.
//
// Handshake: start is a single-cycle request, accepted whenever busy is
// low; done pulses for exactly one cycle and code/unstable are valid in
// that cycle, with code held stable until the next done.
//
// Build option: TTP_GLITCH_CHECK_EN samples `out` a second time one edge
// earlier in each window and reports any disagreement on `unstable`.
// ----------------------------------------------------------------------------
module truth_table_probe
  import truth_table_probe_pkg::*;
#(
  parameter int SETTLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic [7:0] code,
  output logic       unstable,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  input  logic       out,
  output logic [1:0] dbg_state
);

  state_e     state_q, state_d;
  logic [2:0] vec_q, vec_d;
  logic [7:0] shadow_q, shadow_d;
  logic [7:0] code_q, code_d;
  logic [7:0] shadow_sampled;
  logic       start_accept;
  logic       last_vector;
  logic       timer_load;
  logic       timer_expired;

`ifdef TTP_GLITCH_CHECK_EN
  logic timer_early;
  logic early_q, early_d;
  logic flag_q, flag_d;
  logic unstable_q, unstable_d;
  logic mismatch;
`endif

  // --------------------------------------------------------------------------
  // Settle timer
  // --------------------------------------------------------------------------
  settle_timer #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (timer_load),
    .expired(timer_expired)
`ifdef TTP_GLITCH_CHECK_EN
    ,
    .early  (timer_early)
`endif
  );

  // Restart the timer on every entry into DRIVE.
  always_comb begin
    timer_load = (state_d == DRIVE) && (state_q != DRIVE);
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // --------------------------------------------------------------------------
  // FSM: next state
  // --------------------------------------------------------------------------
  always_comb begin
    last_vector  = (vec_q == LAST_VECTOR);
    // FINISH is the non-busy cycle that carries the done pulse; it behaves
    // like IDLE towards start, so a request in the done cycle is taken.
    start_accept = start && ((state_q == IDLE) || (state_q == FINISH));
    state_d      = state_q;
    unique case (state_q)
      IDLE:    if (start_accept) state_d = DRIVE;
      DRIVE:   if (timer_expired) state_d = SAMPLE;
      SAMPLE:  state_d = last_vector ? FINISH : DRIVE;
      FINISH:  state_d = start_accept ? DRIVE : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // FSM: outputs
  // --------------------------------------------------------------------------
  always_comb begin
    busy      = (state_q == DRIVE) || (state_q == SAMPLE);
    done      = (state_q == FINISH);
    code      = code_q;
    dbg_state = state_q;
    {in1, in2, in3} = 3'b000;
    if (busy) begin
      {in1, in2, in3} = vec_q;
    end
`ifdef TTP_GLITCH_CHECK_EN
    unstable = done && unstable_q;
`else
    unstable = 1'b0;
`endif
  end

  // --------------------------------------------------------------------------
  // Vector counter, shadow and code registers
  // --------------------------------------------------------------------------
  always_comb begin
    shadow_sampled = shadow_q;
    shadow_sampled[vec_bit_index(vec_q)] = out;

    vec_d    = vec_q;
    shadow_d = shadow_q;
    code_d   = code_q;

    if (start_accept) begin
      vec_d    = '0;
      shadow_d = '0;
    end else if (state_q == SAMPLE) begin
      shadow_d = shadow_sampled;
      if (last_vector) begin
        // code changes only here, so it keeps the previous result for
        // the whole run.
        code_d = shadow_sampled;
      end else begin
        vec_d = vec_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vec_q    <= '0;
      shadow_q <= '0;
      code_q   <= '0;
    end else begin
      vec_q    <= vec_d;
      shadow_q <= shadow_d;
      code_q   <= code_d;
    end
  end

`ifdef TTP_GLITCH_CHECK_EN
  // --------------------------------------------------------------------------
  // Glitch check: early sample vs. final sample, sticky for the run
  // --------------------------------------------------------------------------
  always_comb begin
    mismatch   = (state_q == SAMPLE) && (out != early_q);
    early_d    = early_q;
    flag_d     = flag_q;
    unstable_d = unstable_q;

    if ((state_q == DRIVE) && timer_early) begin
      early_d = out;
    end

    if (start_accept) begin
      flag_d = 1'b0;
    end else if (mismatch) begin
      flag_d = 1'b1;
    end

    if ((state_q == SAMPLE) && last_vector) begin
      unstable_d = flag_q || mismatch;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      early_q    <= 1'b0;
      flag_q     <= 1'b0;
      unstable_q <= 1'b0;
    end else begin
      early_q    <= early_d;
      flag_q     <= flag_d;
      unstable_q <= unstable_d;
    end
  end
`endif

endmodule

// File: tb/tb_truth_table_probe.sv
// ----------------------------------------------------------------------------
// tb_truth_table_probe
//
// Bench for truth_table_probe. Two instances: dut0 with SETTLE_CYCLES=4 and
// dut1 with SETTLE_CYCLES=1. Each drives a gate model that looks up its
// output from a gate code; dut0's gate can be made to toggle every cycle
// while vector 011 is applied. Expected results are pushed when a run is
// started; a monitor per instance pops and compares on every done.
// ----------------------------------------------------------------------------
module tb_truth_table_probe;

  localparam int LAT0 = 8 * (4 + 1);
  localparam int LAT1 = 8 * (1 + 1);
  localparam int EW   = 49;  // {done cycle[32], mask[8], code[8], unstable}

`ifdef TTP_GLITCH_CHECK_EN
  localparam logic EXP_GLITCH = 1'b1;
`else
  localparam logic EXP_GLITCH = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Clock / reset
  // --------------------------------------------------------------------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // --------------------------------------------------------------------------
  // DUTs and gate models
  // --------------------------------------------------------------------------
  logic       start0, busy0, done0, unst0, i01, i02, i03, out0;
  logic [7:0] code0;
  logic [1:0] dbg0;
  logic       start1, busy1, done1, unst1, i11, i12, i13, out1;
  logic [7:0] code1;
  logic [1:0] dbg1;

  logic [7:0] gate0, gate1;
  logic       glitch_en;
  logic       tog = 1'b0;
  logic [2:0] v0, v1;

  always @(posedge clk) tog <= ~tog;

  always_comb begin
    v0   = {i01, i02, i03};
    out0 = gate0[3'd7 - v0];
    if (glitch_en && (v0 == 3'd3)) out0 = tog;
  end

  always_comb begin
    v1   = {i11, i12, i13};
    out1 = gate1[3'd7 - v1];
  end

  truth_table_probe #(.SETTLE_CYCLES(4)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
    .code(code0), .unstable(unst0), .in1(i01), .in2(i02), .in3(i03),
    .out(out0), .dbg_state(dbg0)
  );

  truth_table_probe #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
    .code(code1), .unstable(unst1), .in1(i11), .in2(i12), .in3(i13),
    .out(out1), .dbg_state(dbg1)
  );

  // --------------------------------------------------------------------------
  // Scoreboard
  // --------------------------------------------------------------------------
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] exp1_q[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare_done(input string tag, input logic [EW-1:0] e,
                              input logic [7:0] c, input logic u);
    check({tag, "_code"}, 32'(c & e[16:9]), 32'(e[8:1] & e[16:9]));
    check({tag, "_unstable"}, 32'(u), 32'(e[0]));
    check({tag, "_latency"}, 32'(cyc), e[48:17]);
  endtask

  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done0_unexpected: got done=1 expected no pending run (cycle %0d)", cyc);
      end else begin
        compare_done("dut0", exp_q.pop_front(), code0, unst0);
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL done1_unexpected: got done=1 expected no pending run (cycle %0d)", cyc);
      end else begin
        compare_done("dut1", exp1_q.pop_front(), code1, unst1);
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver tasks (called at a negedge; return at the negedge after E0)
  // --------------------------------------------------------------------------
  task automatic launch(input int which, input logic [7:0] c,
                        input logic [7:0] m, input logic u, input bit expect_done);
    if (which == 0) begin
      start0 = 1'b1;
      if (expect_done) exp_q.push_back({32'(cyc + 1 + LAT0), m, c, u});
    end else begin
      start1 = 1'b1;
      if (expect_done) exp1_q.push_back({32'(cyc + 1 + LAT1), m, c, u});
    end
    @(negedge clk);
    start0 = 1'b0;
    start1 = 1'b0;
  endtask

  task automatic wait_drain(input int which);
    int pending;
    pending = (which == 0) ? exp_q.size() : exp1_q.size();
    for (int i = 0; i < 200 && pending != 0; i++) begin
      @(negedge clk);
      pending = (which == 0) ? exp_q.size() : exp1_q.size();
    end
    checks++;
    if (pending != 0) begin
      errors++;
      $display("FAIL drain%0d_timeout: got %0d pending runs expected 0", which, pending);
      if (which == 0) exp_q.delete();
      else exp1_q.delete();
    end
  endtask

  // --------------------------------------------------------------------------
  // Directed stimulus
  // --------------------------------------------------------------------------
  logic [7:0] tbl [5];
  logic [7:0] prev_code;
  bit         seen;

  initial begin
    tbl = '{8'hA8, 8'hFF, 8'h00, 8'h0F, 8'h55};
    rst = 1'b1; start0 = 1'b0; start1 = 1'b0;
    gate0 = 8'h00; gate1 = 8'hA8; glitch_en = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_code", 32'(code0), 32'h00);
    check("rst_unstable", 32'(unst0), 32'd0);
    check("rst_inputs", 32'({i01, i02, i03}), 32'd0);
    check("rst_state", 32'(dbg0), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Gate table: 0xA8, const-1, const-0, in1, in3
    prev_code = 8'h00;
    for (int i = 0; i < 5; i++) begin
      gate0 = tbl[i];
      launch(0, tbl[i], 8'hFF, 1'b0, 1'b1);
      check("run_busy", 32'(busy0), 32'd1);
      repeat (5) @(negedge clk);
      check("run_vector1", 32'({i01, i02, i03}), 32'd1);
      check("run_code_held", 32'(code0), 32'(prev_code));
      wait_drain(0);
      check("after_busy", 32'(busy0), 32'd0);
      prev_code = tbl[i];
      @(negedge clk);
    end

    // Back-to-back: start in the done cycle, gate swapped to in1
    gate0 = 8'hA8;
    launch(0, 8'hA8, 8'hFF, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (done0 === 1'b1) seen = 1'b1;
    end
    check("b2b_first_done_seen", 32'(seen), 32'd1);
    gate0 = 8'h0F;
    launch(0, 8'h0F, 8'hFF, 1'b0, 1'b1);
    repeat (18) @(negedge clk);
    check("b2b_code_held", 32'(code0), 32'hA8);
    check("b2b_busy", 32'(busy0), 32'd1);
    wait_drain(0);
    @(negedge clk);

    // start re-pulsed at cycle 10 of a run is ignored
    gate0 = 8'hA8;
    launch(0, 8'hA8, 8'hFF, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_drain(0);
    @(negedge clk);

    // Reset at cycle 20 of a run: no done, everything back to reset values
    gate0 = 8'h55;
    launch(0, 8'h55, 8'hFF, 1'b0, 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_busy", 32'(busy0), 32'd0);
    check("midrst_code", 32'(code0), 32'h00);
    check("midrst_inputs", 32'({i01, i02, i03}), 32'd0);
    check("midrst_done", 32'(done0), 32'd0);
    rst = 1'b0;
    repeat (60) @(negedge clk);
    launch(0, 8'h55, 8'hFF, 1'b0, 1'b1);
    wait_drain(0);
    @(negedge clk);

    // Output toggling during vector 011, then a clean run
    gate0 = 8'hA8;
    glitch_en = 1'b1;
    launch(0, 8'hA8, 8'hEF, EXP_GLITCH, 1'b1);
    wait_drain(0);
    glitch_en = 1'b0;
    @(negedge clk);
    launch(0, 8'hA8, 8'hFF, 1'b0, 1'b1);
    wait_drain(0);
    @(negedge clk);

    // SETTLE_CYCLES = 1 instance
    check("s1_rst_code", 32'(code1), 32'h00);
    launch(1, 8'hA8, 8'hFF, 1'b0, 1'b1);
    wait_drain(1);
    @(negedge clk);
    gate1 = 8'h0F;
    launch(1, 8'h0F, 8'hFF, 1'b0, 1'b1);
    wait_drain(1);

    repeat (5) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
